// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared CPU constants: ALU opcodes, multiply/divide unit op encodings and the
// multiply/divide unit state encoding, plus small op-decoding helpers.
// ----------------------------------------------------------------------------
package mult_div_unit_pkg;

    // Datapath width the multiply/divide unit is built for.
    localparam int MDU_WIDTH = 32;

    // Width of the multiply/divide iteration counter.
    localparam int MDU_CNT_W = 6;

    // Main ALU operation codes.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Multiply/divide operation select.
    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    // True for the two's-complement operations (MULT, DIV).
    function automatic logic mdu_op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    // True for the multiply operations (MULT, MULTU).
    function automatic logic mdu_op_is_mul(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the pipeline and the multiply/divide unit.
//   start, op, a, b     : operation request (op/a/b sampled with start)
//   mthi_we, mtlo_we, wd: direct HI/LO writes
//   hi, lo              : architectural HI/LO contents
//   busy, done          : in-flight flag and one-cycle completion pulse
// master = pipeline side, slave = multiply/divide unit.
// ----------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, mthi_we, mtlo_we, wd,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, mthi_we, mtlo_we, wd,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/mult_div_unit_signfix.sv
// ----------------------------------------------------------------------------
// mdu_signfix
// Combinational sign handling for the multiply/divide unit.
// Entry path : turns the raw operands into magnitudes and reports their signs.
// Result path: applies the sign correction to the raw unsigned result.
//   is_signed_i        : operation is MULT/DIV
//   a_i, b_i           : raw operands
//   mag_a_o, mag_b_o   : operand magnitudes
//   a_neg_o, b_neg_o   : operand was negative (signed ops only)
//   is_mul_i           : result in raw_i is a 64-bit product
//   neg_prod_i         : negate the full product
//   neg_quo_i          : negate the quotient (low half)
//   neg_rem_i          : negate the remainder (high half)
//   raw_i / fixed_o    : {HI,LO} before / after sign correction
// ----------------------------------------------------------------------------
module mdu_signfix #(
    parameter int WIDTH = 32
) (
    input  logic                 is_signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [WIDTH-1:0]     mag_a_o,
    output logic [WIDTH-1:0]     mag_b_o,
    output logic                 a_neg_o,
    output logic                 b_neg_o,
    input  logic                 is_mul_i,
    input  logic                 neg_prod_i,
    input  logic                 neg_quo_i,
    input  logic                 neg_rem_i,
    input  logic [2*WIDTH-1:0]   raw_i,
    output logic [2*WIDTH-1:0]   fixed_o
);

    // Two's-complement negation of a single word.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a double word.
    function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand signs and magnitudes. Magnitude of the most negative value is
    // its own bit pattern, which is correct when read as unsigned.
    always_comb begin
        a_neg_o = is_signed_i & a_i[WIDTH-1];
        b_neg_o = is_signed_i & b_i[WIDTH-1];
        if (a_neg_o) begin
            mag_a_o = neg_w(a_i);
        end else begin
            mag_a_o = a_i;
        end
        if (b_neg_o) begin
            mag_b_o = neg_w(b_i);
        end else begin
            mag_b_o = b_i;
        end
    end

    // Result sign correction: whole product, or quotient/remainder separately.
    always_comb begin
        fixed_o = raw_i;
        if (is_mul_i) begin
            if (neg_prod_i) begin
                fixed_o = neg_d(raw_i);
            end else begin
                fixed_o = raw_i;
            end
        end else begin
            if (neg_rem_i) begin
                fixed_o[2*WIDTH-1:WIDTH] = neg_w(raw_i[2*WIDTH-1:WIDTH]);
            end else begin
                fixed_o[2*WIDTH-1:WIDTH] = raw_i[2*WIDTH-1:WIDTH];
            end
            if (neg_quo_i) begin
                fixed_o[WIDTH-1:0] = neg_w(raw_i[WIDTH-1:0]);
            end else begin
                fixed_o[WIDTH-1:0] = raw_i[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring, one bit per cycle on operand
// magnitudes; a final FIX cycle applies signs and commits HI/LO.
//   clk  : clock, all state changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : mult_div_unit_if.slave (start/op/a/b, mthi_we/mtlo_we/wd,
//          hi/lo, busy/done)
// Timing: accepted start -> 32 CALC cycles + 1 FIX cycle with busy high, then
// one cycle with done high, busy low and the new HI/LO visible.
// ----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    mult_div_unit_if.slave    bus
);

    import mult_div_unit_pkg::*;

    localparam logic [MDU_CNT_W-1:0] TERM_CNT = MDU_CNT_W'(WIDTH - 1);

    mdu_state_e               state_q;
    logic [MDU_CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]         hi_q;
    logic [WIDTH-1:0]         lo_q;
    logic [WIDTH-1:0]         mcand_q;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]         a_orig_q;   // raw dividend for divide-by-zero
    logic [2*WIDTH-1:0]       acc_q;      // {product} or {remainder, quotient}
    logic                     is_mul_q;
    logic                     neg_prod_q;
    logic                     neg_quo_q;
    logic                     neg_rem_q;
    logic                     div0_q;
    logic                     busy_q;
    logic                     done_q;

    mdu_op_e                  op_s;
    logic                     start_ok_s;
    logic [WIDTH-1:0]         mag_a_s;
    logic [WIDTH-1:0]         mag_b_s;
    logic                     a_neg_s;
    logic                     b_neg_s;
    logic [2*WIDTH-1:0]       fixed_s;
    logic [WIDTH:0]           mul_sum_s;
    logic [WIDTH:0]           div_shift_s;
    logic [WIDTH:0]           div_diff_s;
    logic [2*WIDTH-1:0]       acc_d;
    logic [WIDTH-1:0]         hi_d;
    logic [WIDTH-1:0]         lo_d;

    assign op_s       = mdu_op_e'(bus.op);
    assign start_ok_s = bus.start & (state_q == MDU_IDLE);

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    mdu_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .is_signed_i (mdu_op_is_signed(op_s)),
        .a_i         (bus.a),
        .b_i         (bus.b),
        .mag_a_o     (mag_a_s),
        .mag_b_o     (mag_b_s),
        .a_neg_o     (a_neg_s),
        .b_neg_o     (b_neg_s),
        .is_mul_i    (is_mul_q),
        .neg_prod_i  (neg_prod_q),
        .neg_quo_i   (neg_quo_q),
        .neg_rem_i   (neg_rem_q),
        .raw_i       (acc_q),
        .fixed_o     (fixed_s)
    );

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_q};
        acc_d       = acc_q;
        if (is_mul_q) begin
            // Low half holds the remaining multiplier bits; add into the
            // high half when the current bit is set, then shift right.
            if (acc_q[0]) begin
                mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
            end else begin
                mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            end
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end else begin
            // Shift the next dividend bit into the remainder; keep the
            // difference only if it did not borrow.
            if (!div_diff_s[WIDTH]) begin
                acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final HI/LO values; divide by zero bypasses the sign correction.
    always_comb begin
        hi_d = fixed_s[2*WIDTH-1:WIDTH];
        lo_d = fixed_s[WIDTH-1:0];
        if (!is_mul_q && div0_q) begin
            hi_d = a_orig_q;
            lo_d = {WIDTH{1'b1}};
        end else begin
            hi_d = fixed_s[2*WIDTH-1:WIDTH];
            lo_d = fixed_s[WIDTH-1:0];
        end
    end

    // Sequencer, datapath registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MDU_IDLE;
            cnt_q      <= {MDU_CNT_W{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            mcand_q    <= {WIDTH{1'b0}};
            a_orig_q   <= {WIDTH{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
            is_mul_q   <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MDU_IDLE: begin
                    if (start_ok_s) begin
                        // Start wins over a same-cycle HI/LO write.
                        state_q    <= MDU_CALC;
                        busy_q     <= 1'b1;
                        cnt_q      <= {MDU_CNT_W{1'b0}};
                        acc_q      <= {{WIDTH{1'b0}}, mag_a_s};
                        mcand_q    <= mag_b_s;
                        a_orig_q   <= bus.a;
                        is_mul_q   <= mdu_op_is_mul(op_s);
                        neg_prod_q <= a_neg_s ^ b_neg_s;
                        neg_quo_q  <= a_neg_s ^ b_neg_s;
                        neg_rem_q  <= a_neg_s;
                        div0_q     <= (bus.b == {WIDTH{1'b0}});
                    end else begin
                        if (bus.mthi_we) begin
                            hi_q <= bus.wd;
                        end
                        if (bus.mtlo_we) begin
                            lo_q <= bus.wd;
                        end
                    end
                end
                MDU_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + {{(MDU_CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == TERM_CNT) begin
                        state_q <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= MDU_IDLE;
                end
                default: begin
                    state_q <= MDU_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, one-cycle request to begin an operation.
REQ-005 The block SHALL have port op, input, 2, operation select: MULT=0, MULTU=1, DIV=2, DIVU=3; sampled with start.
REQ-006 The block SHALL have ports a and b, input, 32 each, operands (rs, rt); sampled with start.
REQ-007 The block SHALL have ports mthi_we and mtlo_we, input, 1 each, direct-write strobes for HI and LO.
REQ-008 The block SHALL have port wd, input, 32, data written by mthi_we/mtlo_we.
REQ-009 The block SHALL have ports hi and lo, output, 32 each, current HI/LO contents, read by writeback for MFHI/MFLO into the register file.
REQ-010 The block SHALL have port busy, output, 1, high while an operation is in flight; the pipeline stalls MFHI/MFLO/MTHI/MTLO/new start while it is high.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse when HI/LO hold a new result.

Function
REQ-012 The block SHALL implement states IDLE, CALC, FIX; transitions IDLE->CALC on start, CALC->FIX after exactly 32 iterations, FIX->IDLE unconditionally.
REQ-013 The block SHALL accept start only in IDLE with busy low; start while busy SHALL be ignored with no effect on state, operands or HI/LO.
REQ-014 The block SHALL drive busy high from the cycle after an accepted start through the FIX cycle inclusive: 33 cycles.
REQ-015 The block SHALL update HI and LO at the clock edge ending FIX and assert done for exactly the following cycle, with busy low in that cycle.
REQ-016 Multiply SHALL be shift-add, one bit per cycle; {HI,LO} SHALL equal the full 64-bit product, signed two's complement for MULT and unsigned for MULTU.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle; LO SHALL be the quotient and HI the remainder.
REQ-018 Signed ops SHALL run on magnitudes; FIX SHALL negate the product if the operand signs differ, negate the quotient if the signs differ, and give the remainder the dividend's sign.
REQ-019 Divide by zero SHALL give LO=0xFFFFFFFF and HI=dividend a, for both DIV and DIVU.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-021 mthi_we/mtlo_we in IDLE SHALL write wd to HI/LO at the next edge; both asserted together SHALL write both registers.
REQ-022 mthi_we/mtlo_we while busy SHALL be ignored.
REQ-023 start together with mthi_we or mtlo_we SHALL let start win, and the write SHALL be discarded.
REQ-024 hi and lo SHALL hold their previous values throughout CALC and FIX; intermediate values are never visible.

Reset
REQ-025 Reset SHALL force state IDLE and HI=LO=0, busy=0, done=0, and clear the iteration counter and internal accumulators.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse and no HI/LO update.
REQ-027 Reset SHALL override start and the mt strobes in the same cycle.

Structure
REQ-028 The op encodings and the state encoding SHALL live in the shared CPU constants package alongside the ALU opcodes.
REQ-029 The iteration counter SHALL be 6 bits, with the terminal count derived from WIDTH.
REQ-030 The design SHALL use one sub-module, mdu_signfix: combinational magnitude extraction and result negation, shared by the entry and FIX paths.
REQ-031 The block SHALL have no multiplier or divider primitives inferred.

Verification
REQ-032 The bench SHALL drive MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then done, with HI=0xFFFFFFFE and LO=0x00000001.
REQ-033 The bench SHALL drive MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 The bench SHALL drive DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100.
REQ-035 The bench SHALL write mthi wd=0x1234 in IDLE, start MULTU 3x4, and pulse start (DIVU 9/3) and mtlo mid-CALC -> the extra start and mtlo are ignored; final HI=0, LO=12; done pulses exactly once.
REQ-036 The bench SHALL assert rst at CALC cycle 10 -> next cycle busy=0, done=0, HI=LO=0, and no later done pulse.
REQ-037 The bench SHALL drive start (MULTU 2x2) and mtlo_we (wd=7) in the same IDLE cycle -> LO=4 after done, with 7 never appearing on lo.
